// File: rtl/comparador_serial_der_izq_if.sv
// Handshake and operand/result bundle for the bit-serial comparator.
// The master side issues requests and the slave side answers them.
interface comparador_serial_der_izq_if #(
  parameter int K = 4
);
  logic         start;
  logic [K-1:0] A;
  logic [K-1:0] B;
  logic         busy;
  logic         done;
  logic         M;
  logic         N;
  logic         Z;
  logic         EQ;

  modport master (
    output start, A, B,
    input  busy, done, M, N, Z, EQ
  );

  modport slave (
    input  start, A, B,
    output busy, done, M, N, Z, EQ
  );
endinterface

// File: rtl/comparador_serial_der_izq.sv
// Bit-serial magnitude comparator: scans A and B LSB first, one bit per clock,
// and publishes M (A>B), N (A<B), Z (=M) and EQ behind a start/done handshake.
module comparador_serial_der_izq #(
  parameter int K = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  comparador_serial_der_izq_if.slave    bus
);

  localparam int CNT_W = (K > 1) ? $clog2(K + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [K-1:0]       sa_q, sa_d;
  logic [K-1:0]       sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m_run_q, m_run_d;
  logic               n_run_q, n_run_d;
  logic               m_out_q, m_out_d;
  logic               n_out_q, n_out_d;
  logic               eq_out_q, eq_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               m_next_s;
  logic               n_next_s;

  // Running flags after the current bit: a differing bit overrides, so later
  // (higher-order) bits dominate the earlier ones.
  always_comb begin
    m_next_s = m_run_q;
    n_next_s = n_run_q;
    if (sa_q[0] != sb_q[0]) begin
      m_next_s = sa_q[0];
      n_next_s = sb_q[0];
    end else begin
      m_next_s = m_run_q;
      n_next_s = n_run_q;
    end
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    m_run_d  = m_run_q;
    n_run_d  = n_run_q;
    m_out_d  = m_out_q;
    n_out_d  = n_out_q;
    eq_out_d = eq_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.A;
          sb_d    = bus.B;
          cnt_d   = '0;
          m_run_d = 1'b0;
          n_run_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      RUN: begin
        m_run_d = m_next_s;
        n_run_d = n_next_s;
        sa_d    = sa_q >> 1'b1;
        sb_d    = sb_q >> 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(K - 1)) begin
          m_out_d  = m_next_s;
          n_out_d  = n_next_s;
          eq_out_d = ~m_next_s & ~n_next_s;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = RUN;
        end
      end

      // The edge leaving DONE may already accept the next request.
      DONE: begin
        if (bus.start) begin
          sa_d    = bus.A;
          sb_d    = bus.B;
          cnt_d   = '0;
          m_run_d = 1'b0;
          n_run_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      m_run_q  <= 1'b0;
      n_run_q  <= 1'b0;
      m_out_q  <= 1'b0;
      n_out_q  <= 1'b0;
      eq_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      m_run_q  <= m_run_d;
      n_run_q  <= n_run_d;
      m_out_q  <= m_out_d;
      n_out_q  <= n_out_d;
      eq_out_q <= eq_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.M    = m_out_q;
  assign bus.N    = n_out_q;
  assign bus.Z    = m_out_q;
  assign bus.EQ   = eq_out_q;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Self-checking bench for comparador_serial_der_izq: directed and random
// comparisons against an integer-magnitude reference model.
module tb_comparador_serial_der_izq;

  localparam int K = 4;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  comparador_serial_der_izq_if #(.K(K)) bus ();

  comparador_serial_der_izq #(.K(K)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "global timeout");
  end

  // Reference model: plain unsigned magnitude comparison.
  function automatic logic ref_gt(input logic [K-1:0] a, input logic [K-1:0] b);
    return (int'(a) > int'(b));
  endfunction
  function automatic logic ref_lt(input logic [K-1:0] a, input logic [K-1:0] b);
    return (int'(a) < int'(b));
  endfunction

  // Issue one request from a negedge; returns edges from accept to done seen.
  task automatic do_op(input logic [K-1:0] a, input logic [K-1:0] b,
                       output int edges, output bit to);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    edges = 0;
    to    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) break;
      if (i == 19) to = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.M, bus.N, bus.Z, bus.EQ} !== 6'b000001) begin
      bad++;
      $display("FAIL reset_outputs: got busy,done,M,N,Z,EQ=%b required 000001",
               {bus.busy, bus.done, bus.M, bus.N, bus.Z, bus.EQ});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [K-1:0] va [6];
    logic [K-1:0] vb [6];
    int  edges;
    bit  to;
    va[0] = 4'b1010; vb[0] = 4'b0110;
    va[1] = 4'b0011; vb[1] = 4'b0101;
    va[2] = 4'b1001; vb[2] = 4'b1001;
    va[3] = 4'b1000; vb[3] = 4'b0111;
    va[4] = 4'b0111; vb[4] = 4'b1000;
    va[5] = 4'b0000; vb[5] = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], edges, to);
      total++;
      if (to || edges != K) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d edges (timeout=%0b) required %0d",
                 i, edges, to, K);
      end
      total++;
      if ({bus.M, bus.N, bus.Z, bus.EQ} !==
          {ref_gt(va[i], vb[i]), ref_lt(va[i], vb[i]), ref_gt(va[i], vb[i]),
           (va[i] == vb[i])}) begin
        bad++;
        $display("FAIL directed_result[%0d]: A=%b B=%b got M,N,Z,EQ=%b required %b%b%b%b",
                 i, va[i], vb[i], {bus.M, bus.N, bus.Z, bus.EQ},
                 ref_gt(va[i], vb[i]), ref_lt(va[i], vb[i]), ref_gt(va[i], vb[i]),
                 (va[i] == vb[i]));
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL directed_idle[%0d]: got done=%b busy=%b required 0 0",
                 i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_ignore_start();
    int  dones;
    bit  m_seen;
    bit  busy_ok;
    bus.start = 1'b1;
    bus.A     = 4'b1100;
    bus.B     = 4'b0011;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    busy_ok   = (bus.busy === 1'b1) && (bus.Z === 1'b0);
    bus.start = 1'b1;
    bus.A     = 4'b0000;
    bus.B     = 4'b1111;
    @(negedge clk);
    bus.start = 1'b0;
    dones  = 0;
    m_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        m_seen = bus.Z;
      end
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL ignore_busy_during_run: got busy/Z not 1/0 during RUN, required busy=1 Z=0");
    end
    total++;
    if (dones != 1 || m_seen !== 1'b1 || bus.Z !== 1'b1) begin
      bad++;
      $display("FAIL ignore_start: got dones=%0d Z=%b required dones=1 Z=1", dones, bus.Z);
    end
  endtask

  task automatic test_reset_abort();
    int  dones;
    int  edges;
    bit  to;
    bus.start = 1'b1;
    bus.A     = 4'b1110;
    bus.B     = 4'b0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.M, bus.N, bus.Z, bus.EQ} !== 6'b000001) begin
      bad++;
      $display("FAIL abort_outputs: got busy,done,M,N,Z,EQ=%b required 000001",
               {bus.busy, bus.done, bus.M, bus.N, bus.Z, bus.EQ});
    end
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    total++;
    if (dones != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b required 0 0", dones, bus.busy);
    end
    do_op(4'b0101, 4'b0011, edges, to);
    total++;
    if (to || edges != K || {bus.M, bus.N, bus.Z, bus.EQ} !== 4'b1010) begin
      bad++;
      $display("FAIL abort_recover: got edges=%0d M,N,Z,EQ=%b required %0d 1010",
               edges, {bus.M, bus.N, bus.Z, bus.EQ}, K);
    end
  endtask

  task automatic test_random();
    logic [K-1:0] a;
    logic [K-1:0] b;
    int  edges;
    bit  to;
    for (int i = 0; i < 30; i++) begin
      a = K'($urandom_range(0, (1 << K) - 1));
      b = (i % 5 == 0) ? a : K'($urandom_range(0, (1 << K) - 1));
      do_op(a, b, edges, to);
      total++;
      if (to || edges != K ||
          {bus.M, bus.N, bus.Z, bus.EQ} !== {ref_gt(a, b), ref_lt(a, b), ref_gt(a, b), (a == b)}) begin
        bad++;
        $display("FAIL random[%0d]: A=%b B=%b got edges=%0d M,N,Z,EQ=%b required %0d %b%b%b%b",
                 i, a, b, edges, {bus.M, bus.N, bus.Z, bus.EQ}, K,
                 ref_gt(a, b), ref_lt(a, b), ref_gt(a, b), (a == b));
      end
      total++;
      if (bus.M && bus.N) begin
        bad++;
        $display("FAIL random_exclusive[%0d]: got M=1 N=1 required not both", i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [K-1:0] qa [$];
    logic [K-1:0] qb [$];
    logic [K-1:0] a;
    logic [K-1:0] b;
    logic [K-1:0] ea;
    logic [K-1:0] eb;
    bit  exp_done;
    int  n_ops;
    n_ops = 8;
    bus.start = 1'b1;
    for (int idx = 0; idx < n_ops * (K + 1); idx++) begin
      a = K'($urandom_range(0, (1 << K) - 1));
      b = K'($urandom_range(0, (1 << K) - 1));
      bus.A = a;
      bus.B = b;
      if (idx % (K + 1) == 0) begin
        qa.push_back(a);
        qb.push_back(b);
      end
      @(posedge clk);
      @(negedge clk);
      exp_done = (idx % (K + 1) == K);
      if (idx == n_ops * (K + 1) - 1) bus.start = 1'b0;
      total++;
      if (bus.done !== exp_done) begin
        bad++;
        $display("FAIL b2b_done[%0d]: got done=%b required %b", idx, bus.done, exp_done);
      end
      if (exp_done && qa.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        total++;
        if ({bus.M, bus.N, bus.Z, bus.EQ} !==
            {ref_gt(ea, eb), ref_lt(ea, eb), ref_gt(ea, eb), (ea == eb)}) begin
          bad++;
          $display("FAIL b2b_result[%0d]: A=%b B=%b got M,N,Z,EQ=%b required %b%b%b%b",
                   idx, ea, eb, {bus.M, bus.N, bus.Z, bus.EQ},
                   ref_gt(ea, eb), ref_lt(ea, eb), ref_gt(ea, eb), (ea == eb));
        end
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got busy=%b required 0", bus.busy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
